// File: rtl/dco_nco_pkg.sv
// Shared ADPLL definitions used by the loop filter and the DCO/NCO stage.
//   CTRL_W        : loop-filter control-word width
//   ACC_W_DEFAULT : default phase accumulator width
//   LFSR_W/TAPS   : 8-bit dither LFSR, polynomial x^8+x^6+x^5+x^4+1
//   lfsr_next()   : one Fibonacci LFSR step (shift toward MSB)
package dco_nco_pkg;

    localparam int unsigned CTRL_W        = 13;
    localparam int unsigned ACC_W_DEFAULT = 24;
    localparam int unsigned LFSR_W        = 8;
    // Tap bits 7,5,4,3 correspond to x^8, x^6, x^5, x^4.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dco_nco_fb_divider.sv
// Feedback clock divider: toggles fb_clk every DIV_N/2 tick pulses, giving a
// clock at the tick source's frequency divided by DIV_N.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   tick   in  one-cycle event pulse (accumulator carry)
//   fb_clk out divided clock, registered
module dco_nco_fb_divider #(
    parameter int unsigned DIV_N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic fb_clk
);

    localparam int unsigned HALF  = DIV_N / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    if (DIV_N < 2 || (DIV_N % 2) != 0) begin : g_bad_div_n
        $error("DIV_N must be even and at least 2");
    end

    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic             fb_clk_d;
    logic             terminal;

    always_comb begin
        half_cnt_d = half_cnt_q;
        fb_clk_d   = fb_clk;
        terminal   = (half_cnt_q == CNT_W'(HALF - 1));
        if (tick) begin
            if (terminal) begin
                half_cnt_d = '0;
                fb_clk_d   = ~fb_clk;
            end else begin
                half_cnt_d = half_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt_q <= '0;
            fb_clk     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            fb_clk     <= fb_clk_d;
        end
    end

endmodule

// File: rtl/dco_nco.sv
// Numerically controlled oscillator (DCO stage of the ADPLL).
// Stage 1 turns the signed loop-filter word into a clamped FCW around
// FCW_CENTER; stage 2 accumulates it, the accumulator MSB being the recovered
// clock. A divide-by-DIV_N feedback clock is derived from accumulator carries.
// Optional feature macro: DCO_DITHER_EN adds LFSR dither at the accumulator
// input only (fcw_q and the saturation flags stay undithered).
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   en      in  accumulator enable
//   k_in    in  signed control word from the loop filter
//   fcw_q   out registered, clamped FCW
//   sat_hi  out fcw_q clamped at FCW_MAX
//   sat_lo  out fcw_q clamped at FCW_MIN
//   dco_out out accumulator MSB
//   wrap    out one-cycle pulse on accumulator carry-out
//   fb_clk  out dco_out frequency divided by DIV_N
module dco_nco
    import dco_nco_pkg::*;
#(
    parameter int unsigned      ACC_W      = ACC_W_DEFAULT,
    parameter logic [ACC_W-1:0] FCW_CENTER = 24'h100000,
    parameter int unsigned      K_SHIFT    = 4,
    parameter logic [ACC_W-1:0] FCW_MIN    = 24'h010000,
    parameter logic [ACC_W-1:0] FCW_MAX    = 24'h200000,
    parameter int unsigned      DIV_N      = 8,
    parameter int unsigned      DITHER_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [CTRL_W-1:0] k_in,
    output logic [ACC_W-1:0]         fcw_q,
    output logic                     sat_hi,
    output logic                     sat_lo,
    output logic                     dco_out,
    output logic                     wrap,
    output logic                     fb_clk
);

    // Two guard bits keep the sum free of overflow for any legal k_in and shift.
    localparam int unsigned SUM_W = ACC_W + 2;

    if (DITHER_W < 1 || DITHER_W > LFSR_W) begin : g_bad_dither_w
        $error("DITHER_W must be in 1..LFSR_W");
    end

    // ---------------- Stage 1: FCW with clamp ----------------
    logic signed [SUM_W-1:0] k_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] max_s;
    logic signed [SUM_W-1:0] min_s;
    logic [ACC_W-1:0]        fcw_d;
    logic                    sat_hi_d;
    logic                    sat_lo_d;

    always_comb begin
        k_ext    = {{(SUM_W - CTRL_W){k_in[CTRL_W-1]}}, k_in};
        max_s    = {2'b00, FCW_MAX};
        min_s    = {2'b00, FCW_MIN};
        sum      = $signed({2'b00, FCW_CENTER}) + (k_ext <<< K_SHIFT);
        fcw_d    = sum[ACC_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (sum > max_s) begin
            fcw_d    = FCW_MAX;
            sat_hi_d = 1'b1;
        end else if (sum < min_s) begin
            fcw_d    = FCW_MIN;
            sat_lo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_q  <= FCW_CENTER;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else begin
            fcw_q  <= fcw_d;
            sat_hi <= sat_hi_d;
            sat_lo <= sat_lo_d;
        end
    end

    // ---------------- Stage 2: phase accumulator ----------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_in;
    logic [ACC_W:0]   acc_sum;
    logic             wrap_d;

`ifdef DCO_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign acc_in = fcw_q + ACC_W'(lfsr_q[DITHER_W-1:0]);
`else
    assign acc_in = fcw_q;
`endif

    assign acc_sum = {1'b0, acc_q} + {1'b0, acc_in};
    // Carry only counts when the accumulator actually advances.
    assign wrap_d  = en & acc_sum[ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            dco_out <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= wrap_d;
            if (en) begin
                acc_q   <= acc_sum[ACC_W-1:0];
                dco_out <= acc_sum[ACC_W-1];
            end
        end
    end

    // Driven by the unregistered carry so fb_clk toggles in the same cycle as wrap.
    dco_nco_fb_divider #(
        .DIV_N (DIV_N)
    ) u_fb_divider (
        .clk    (clk),
        .rst    (rst),
        .tick   (wrap_d),
        .fb_clk (fb_clk)
    );

endmodule

// File: doc/dco_nco.md
# dco_nco

Numerically controlled oscillator that forms the DCO stage of the all-digital PLL, directly downstream of the PI loop filter. It converts the filter's signed 13-bit control word into a frequency control word (FCW) around a programmable centre, clamps it, and drives a phase accumulator. The accumulator MSB is the recovered clock. A divide-by-DIV_N feedback clock is returned to the phase detector.

## Interface
- ACC_W, 24: phase accumulator width (bits).
- FCW_CENTER, 24'h100000: free-running FCW when k_in = 0.
- K_SHIFT, 4: left shift applied to k_in before adding to FCW_CENTER.
- FCW_MIN, 24'h010000: lower FCW clamp (unsigned).
- FCW_MAX, 24'h200000: upper FCW clamp (unsigned).
- DIV_N, 8: feedback divide ratio; even, ≥ 2.
- DITHER_W, 4: dither LSB count (used only with the dither macro).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator enable.
- k_in  in  13 (signed)  control word from the loop filter.
- fcw_q  out  ACC_W  registered, clamped FCW.
- sat_hi  out  1  fcw_q clamped at FCW_MAX this cycle.
- sat_lo  out  1  fcw_q clamped at FCW_MIN this cycle.
- dco_out  out  1  accumulator MSB (recovered clock).
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- fb_clk  out  1  dco_out frequency divided by DIV_N.

## Operation
- Stage 1, FCW, every cycle regardless of en:
  - sum = FCW_CENTER + (sign_extend(k_in) <<< K_SHIFT), computed at ACC_W+2 bits signed.
  - If sum > FCW_MAX: fcw_q = FCW_MAX, sat_hi = 1.
  - Else if sum < FCW_MIN (negative sums included): fcw_q = FCW_MIN, sat_lo = 1.
  - Otherwise fcw_q = sum[ACC_W-1:0] and both flags are 0.
- Legal parameters: FCW_MIN ≤ FCW_CENTER ≤ FCW_MAX < 2^(ACC_W-1).
- Stage 2, accumulator: when en = 1, {carry, acc} = acc + fcw_q, computed modulo 2^ACC_W.
  - wrap = carry.
  - dco_out = the new acc[ACC_W-1].
- When en = 0: acc, dco_out, half_cnt and fb_clk hold their values; wrap = 0.
- Feedback divider:
  - half_cnt counts wrap pulses from 0 to DIV_N/2-1.
  - On a wrap while half_cnt = DIV_N/2-1: half_cnt returns to 0 and fb_clk toggles.
- Reset values: acc = 0, fcw_q = FCW_CENTER, sat_hi = sat_lo = 0, dco_out = 0, wrap = 0, half_cnt = 0, fb_clk = 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- k_in to fcw_q/sat flags: 1 cycle.
- k_in to the first effect on acc, dco_out and wrap: 2 cycles.
- wrap asserts in the same cycle that acc crosses zero; fb_clk toggles in that same cycle when the divider terminal count is reached.
- Output period: dco_out period = 2^ACC_W / fcw_q cycles on average; fb_clk period = DIV_N × that.
- Simultaneous events: if en falls in the same cycle a carry would occur, no wrap is produced and the divider does not advance.
- Reset asserted mid-operation clears all state asynchronously. The first accumulation after rst is released uses FCW_CENTER until the newly registered k_in takes effect.
- k_in changes take effect on every clock; there is no handshake (the loop filter updates each cycle).

## Configuration
- DCO_DITHER_EN defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'h01) advances each cycle in which en = 1.
  - Its low DITHER_W bits, zero-extended, are added to fcw_q at the accumulator input only.
  - fcw_q and the sat flags remain undithered.
- DCO_DITHER_EN undefined: no LFSR is built and the accumulator adds fcw_q exactly.

## Structure
- Shared ADPLL package holds:
  - the control-word width constant (13) used by both the loop filter and this block;
  - the ACC_W default;
  - the LFSR tap constant.
- One natural sub-module: fb_divider (half_cnt/fb_clk logic driven by wrap), reusable for other dividers in the loop.

## Test plan
All scenarios use default parameters unless stated.
- Free run: reset, en = 1, k_in = 0 -> fcw_q = 24'h100000; dco_out is 8 cycles high / 8 cycles low; wrap every 16 cycles; fb_clk period 128 cycles.
- Positive and negative control:
  - k_in = +4095 -> fcw_q = 1114096, no saturation flags.
  - k_in = -4096 -> fcw_q = 983040.
  - In both cases fcw_q updates exactly 1 cycle after k_in.
- Saturation:
  - FCW_MAX = 24'h101000, k_in = +4095 -> fcw_q = 24'h101000, sat_hi = 1.
  - FCW_MIN = 24'h0FF000, k_in = -4096 -> fcw_q = 24'h0FF000, sat_lo = 1.
- Enable hold: deassert en for 20 cycles mid-period -> acc, dco_out and fb_clk are frozen, wrap stays 0; phase resumes from the held acc once en returns to 1.
- Reset mid-operation: assert rst asynchronously between clock edges with fb_clk = 1 -> all outputs immediately take their reset values (fcw_q = FCW_CENTER) and the output sequence restarts identically to free run.
- Dither (DCO_DITHER_EN defined, k_in = 0):
  - LFSR sequence starts 8'h01 and has period 255.
  - Average wrap interval over 255 × 16 cycles is within 1% of 2^24 / (2^20 + 7.5).
  - fcw_q stays at 24'h100000.
